// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation for F/D/E/M/W registers,
// a run/pause/halt state machine and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_en,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_HALT} state_t;

  state_t state;
  logic   lu, mp, rt, exc_m, exc_w;
  logic   raw_f_stall, raw_d_stall, raw_d_bubble, raw_e_bubble, raw_m_bubble, raw_w_stall;
  logic   eff_run, cnt_en;

  always_comb begin
    lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mp    = (E_icode == I_JXX) && !e_Cnd;
    rt    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    exc_m = (m_stat != STAT_AOK);
    exc_w = (W_stat != STAT_AOK);

    raw_f_stall  = lu | rt;
    raw_d_stall  = lu;
    raw_d_bubble = mp | (rt & !lu);
    raw_e_bubble = mp | lu;
    raw_m_bubble = exc_m | exc_w;
    raw_w_stall  = exc_w;
  end

  // While reset is held the block behaves as if already in RUN.
  always_comb begin
    eff_run  = reset || (state == ST_RUN);
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    W_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    if (eff_run && run_en) begin
      F_stall  = raw_f_stall;
      D_stall  = raw_d_stall;
      W_stall  = raw_w_stall;
      D_bubble = raw_d_bubble;
      E_bubble = raw_e_bubble;
      M_bubble = raw_m_bubble;
    end else if (!eff_run && (state == ST_HALT)) begin
      M_bubble = 1'b1;
    end
  end

  assign cnt_en = (state == ST_RUN) && run_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_w) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (!run_en) begin
            state <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (run_en) state <= ST_RUN;
        end
        ST_HALT: begin
          state  <= ST_HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= ST_RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_en) begin
      if (cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if ((lu || rt) && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if ((D_bubble || E_bubble) && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, pause, halt, reset and saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic        e_Cnd;
  logic [1:0]  m_stat, W_stat;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [31:0] cycle_cnt, stall_cnt, bubble_cnt;

  logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_halted;
  logic [2:0]  s_cycle_cnt, s_stall_cnt, s_bubble_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run_en(run_en),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .run_en(run_en),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble),
    .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
    .halted(s_halted), .cycle_cnt(s_cycle_cnt), .stall_cnt(s_stall_cnt),
    .bubble_cnt(s_bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                               input logic [3:0] ei, input logic [3:0] ed, input logic ec,
                               input logic [3:0] mi, input logic [1:0] ms, input logic [1:0] ws,
                               input logic re);
    D_icode = di; d_srcA = sa; d_srcB = sb;
    E_icode = ei; E_dstM = ed; e_Cnd = ec;
    M_icode = mi; m_stat = ms; W_stat = ws;
    run_en  = re;
    #1;
  endtask

  task automatic applyIdle(input logic re);
    applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'd0, 2'd0, re);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkCtrl(input string tag, input logic [5:0] expected);
    checkOutput(tag, {26'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}, {26'd0, expected});
  endtask

  task automatic checkCnts(input string tag, input int cyc, input int stl, input int bub);
    checkOutput({tag, "_cycle"},  cycle_cnt,  cyc);
    checkOutput({tag, "_stall"},  stall_cnt,  stl);
    checkOutput({tag, "_bubble"}, bubble_cnt, bub);
  endtask

  // Control vectors below are packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}.
  initial begin
    reset = 1'b1;
    applyIdle(1'b1);
    tick();
    tick();
    checkOutput("reset_halted", {31'd0, halted}, 32'd0);
    checkCnts("reset", 0, 0, 0);
    checkCtrl("reset_ctrl", 6'b000000);

    reset = 1'b0;
    applyIdle(1'b1);
    checkCtrl("idle_ctrl", 6'b000000);
    tick();
    checkCnts("idle", 1, 0, 0);

    applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("loaduse_ctrl", 6'b110100);
    tick();
    checkCnts("loaduse1", 2, 1, 1);
    tick();
    checkCnts("loaduse2", 3, 2, 2);

    applyStimulus(4'h1, 4'hF, 4'hF, 4'hB, 4'hF, 1'b1, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("rnone_ctrl", 6'b000000);
    tick();
    checkCnts("rnone", 4, 2, 2);

    applyStimulus(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("mispredict_ctrl", 6'b001100);
    applyStimulus(4'h9, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("mispredict_ret_ctrl", 6'b101100);
    tick();
    checkCnts("mispredict_ret", 5, 3, 3);

    applyStimulus(4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("jxx_taken_ctrl", 6'b000000);

    applyStimulus(4'h1, 4'hF, 4'h3, 4'h5, 4'h3, 1'b1, 4'h9, 2'd0, 2'd0, 1'b1);
    checkCtrl("ret_loaduse_ctrl", 6'b110100);
    tick();
    checkCnts("ret_loaduse", 6, 4, 4);

    applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 2'd0, 2'd0, 1'b0);
    checkCtrl("pause_req_ctrl", 6'b110001);
    tick();
    applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'd0, 2'd2, 1'b0);
    checkCtrl("pause_excw_ctrl", 6'b110001);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("pause_halted", {31'd0, halted}, 32'd0);
    checkCnts("pause", 6, 4, 4);

    applyIdle(1'b1);
    checkCtrl("pause_exit_ctrl", 6'b110001);
    tick();
    checkCnts("resume0", 6, 4, 4);
    tick();
    checkCnts("resume1", 7, 4, 4);

    applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'd2, 2'd0, 1'b1);
    checkCtrl("exc_m_ctrl", 6'b000010);
    tick();
    applyStimulus(4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 2'd0, 2'd2, 1'b1);
    checkCtrl("exc_w_ctrl", 6'b000011);
    checkOutput("exc_w_halted", {31'd0, halted}, 32'd0);
    tick();
    checkOutput("halt_rise", {31'd0, halted}, 32'd1);
    checkCnts("halt_rise", 9, 4, 4);

    applyStimulus(4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h9, 2'd0, 2'd0, 1'b1);
    checkCtrl("halt_ctrl", 6'b110011);
    tick();
    applyIdle(1'b0);
    tick();
    applyIdle(1'b1);
    tick();
    checkOutput("halt_hold", {31'd0, halted}, 32'd1);
    checkCnts("halt_hold", 9, 4, 4);

    reset = 1'b1;
    applyStimulus(4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 2'd0, 2'd0, 1'b1);
    checkCtrl("reset_in_halt_ctrl", 6'b110100);
    tick();
    reset = 1'b0;
    applyIdle(1'b1);
    checkOutput("reset_from_halt", {31'd0, halted}, 32'd0);
    checkCnts("reset_from_halt", 0, 0, 0);
    checkCtrl("post_reset_ctrl", 6'b000000);

    for (int i = 0; i < 10; i++) tick();
    checkOutput("run10_cycle", cycle_cnt, 32'd10);
    checkOutput("sat_cycle", {29'd0, s_cycle_cnt}, 32'd7);
    checkOutput("sat_stall", {29'd0, s_stall_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit for the five-stage Y86-64 pipeline. Each cycle it generates the stall and bubble controls for the F, D, E, M and W pipeline registers, covering load/use hazards, mispredicted jumps, ret processing and exceptions. It also holds a run/halt state machine and saturating performance counters. It sits beside the stage registers and drives their stall and bubble inputs.

Parameters:
CNT_W, 32, width of each performance counter
RNONE, 4'hF, register ID meaning "no register"; never matches as a hazard

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
run_en  in  1  debug pause; 0 freezes every stage
D_icode  in  4  icode in the D register
d_srcA  in  4  decode srcA
d_srcB  in  4  decode srcB
E_icode  in  4  icode in the E register
E_dstM  in  4  E-register dstM
e_Cnd  in  1  condition result from execute
M_icode  in  4  icode in the M register
m_stat  in  2  memory-stage status
W_stat  in  2  W-register status
F_stall  out  1  hold F register
D_stall  out  1  hold D register
D_bubble  out  1  load nop into D
E_bubble  out  1  load nop into E
M_bubble  out  1  load nop into M
W_stall  out  1  hold W register
halted  out  1  processor stopped
cycle_cnt  out  CNT_W  cycles spent in RUN with run_en=1
stall_cnt  out  CNT_W  cycles with a load/use or ret stall
bubble_cnt  out  CNT_W  cycles with D_bubble or E_bubble asserted

Behaviour:
- Encodings: stat AOK=0, HLT=1, ADR=2, INS=3. icode JXX=7, MRMOVQ=5, POPQ=4'hB, RET=9.
- Hazard terms (combinational, same cycle):
  - lu = E_icode in {MRMOVQ,POPQ} and E_dstM != RNONE and E_dstM in {d_srcA,d_srcB}
  - mp = E_icode==JXX and !e_Cnd
  - rt = RET in {D_icode,E_icode,M_icode}
  - exc_m = m_stat != AOK
  - exc_w = W_stat != AOK
- Raw controls:
  - F_stall = lu | rt
  - D_stall = lu
  - D_bubble = mp | (rt & !lu)
  - E_bubble = mp | lu
  - M_bubble = exc_m | exc_w
  - W_stall = exc_w
- Never assert stall and bubble together on one register. D_stall has priority, which the equations already give.
- State machine (registered): RUN, PAUSE, HALT.
  - Reset -> RUN.
  - RUN: run_en=0 -> PAUSE; exc_w -> HALT. exc_w has priority over run_en.
  - PAUSE: run_en=1 -> RUN. exc_w is ignored while paused, because the pipeline is frozen.
  - HALT: absorbing; only reset leaves it.
- Output gating:
  - RUN: raw controls are passed through.
  - PAUSE, or RUN with run_en=0 in the same cycle: F_stall, D_stall and W_stall = 1; all bubbles = 0. Stalling E and M is done by the caller by not clocking them, so no stall outputs exist for E and M.
  - HALT: F_stall, D_stall and W_stall = 1; M_bubble = 1; D_bubble and E_bubble = 0.
- halted = 1 iff state==HALT, registered. It rises the cycle after the first exc_w in RUN.
- Counters:
  - Reset to 0 and saturate at all-ones (no wrap).
  - cycle_cnt increments when state==RUN and run_en=1.
  - stall_cnt increments in the same condition and when (lu|rt).
  - bubble_cnt increments in the same condition and when (D_bubble|E_bubble).
  - Counters are frozen in PAUSE and HALT.
- Reset values: state RUN, halted 0, all counters 0. Outputs while reset=1 follow RUN gating of the current inputs.
- Reset asserted mid-HALT or mid-PAUSE returns the block to RUN on the next edge.

Test Plan:
- Load/use: E_icode=5, E_dstM=3, d_srcA=3, run_en=1 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt and bubble_cnt +1 per cycle.
- RNONE guard: E_icode=4'hB, E_dstM=4'hF, d_srcB=4'hF -> no stall, no bubble.
- Mispredict: E_icode=7, e_Cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0. The same case combined with D_icode=9 keeps D_bubble=1 and F_stall=1.
- Ret with load/use: M_icode=9 and the lu condition true -> D_stall=1, D_bubble=0, F_stall=1.
- Exception to halt: m_stat=2 for one cycle -> M_bubble=1. Next cycle W_stat=2 -> W_stall=1, M_bubble=1. The following cycle halted=1. Further input changes keep halted=1 and counters fixed. Asserting reset for one cycle -> halted=0 and counters=0.
- Pause and saturation: run_en=0 for 5 cycles -> F_stall, D_stall, W_stall=1 and cycle_cnt unchanged. With CNT_W=3, 10 RUN cycles -> cycle_cnt holds at 7.
